// File: rtl/lcd_defs.sv
// Shared definitions for the LCD bus arbiter: FSM encodings,
// panel opcodes, D/C levels and a one-hot to index helper.
package lcd_defs;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [7:0] LCD_CASET = 8'h2A;
    localparam logic [7:0] LCD_PASET = 8'h2B;
    localparam logic [7:0] LCD_RAMWR = 8'h2C;

    localparam logic DC_CMD = 1'b0;
    localparam logic DC_DAT = 1'b1;

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx |= 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational one-hot picker: first set request at or after the
// pointer (round-robin) or from index 0 (fixed priority).
module lcd_rr_pick
    import lcd_defs::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    input  logic               i_mode,
    output logic [NUM_REQ-1:0] o_gnt
);

    always_comb begin : pick
        int  w_start;
        int  w_idx;
        logic w_found;
        o_gnt   = '0;
        w_found = 1'b0;
        w_start = i_mode ? int'(i_ptr) : 0;
        w_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = w_start + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Transaction-locked arbiter in front of the byte-wide LCD writer.
// Define LCD_ARB_TIMEOUT_EN to enable the wr_done watchdog.
module lcd_bus_arbiter
    import lcd_defs::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ARB_MODE       = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_dc,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           lcd_data,
    output logic                 add_dc,
    output logic                 lcd_wr_en,
    input  logic                 lcd_wr_done,
    output logic                 err_timeout
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("lcd_bus_arbiter: parameter out of range");
    end

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PW-1:0]      r_ptr;
    logic               r_last;
    logic [7:0]         r_data;
    logic               r_dc;
    logic               r_wr_en;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick;
    logic [2:0]         w_gidx;
    logic [PW-1:0]      w_ptr_nxt;
    logic [7:0]         w_gsel_data;
    logic               w_gsel_valid;
    logic               w_gsel_dc;
    logic               w_gsel_last;
    logic               w_hs;
    logic               w_tmo_hit;

    lcd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .i_mode (ARB_MODE != 0),
        .o_gnt  (w_pick)
    );

    // Owner's lane, selected through the one-hot grant.
    always_comb begin
        w_gsel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_gsel_data |= req_data[8*i +: 8];
        end
    end

    assign w_gsel_valid = |(req_valid & r_grant);
    assign w_gsel_dc    = |(req_dc & r_grant);
    assign w_gsel_last  = |(req_last & r_grant);
    assign w_hs         = (r_state == ST_ISSUE) && w_gsel_valid;
    assign w_gidx       = oh2idx(8'(r_grant));
    assign w_ptr_nxt    = (int'(w_gidx) == NUM_REQ - 1) ? '0 : PW'(w_gidx + 3'd1);

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_tmo;

    assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_hs) begin
            r_tmo <= '0;
        end else if (r_state == ST_WAIT && !w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_dc    <= 1'b0;
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_pick;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_hs) begin
                        r_data  <= w_gsel_data;
                        r_dc    <= w_gsel_dc;
                        r_wr_en <= 1'b1;
                        r_last  <= w_gsel_last;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done arriving on the watchdog's last cycle still wins.
                    if (lcd_wr_done) begin
                        r_wr_en <= 1'b0;
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= w_ptr_nxt;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end else if (w_tmo_hit) begin
                        r_wr_en <= 1'b0;
                        r_err   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_ISSUE) ? (req_valid & r_grant) : '0;
    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign lcd_data    = r_data;
    assign add_dc      = r_dc;
    assign lcd_wr_en   = r_wr_en;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter (round-robin, 3 requesters).
// Timeout scenario is compiled in with LCD_ARB_TIMEOUT_EN.
module tb_lcd_bus_arbiter;
    import lcd_defs::*;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_dc;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [7:0]     lcd_data;
    logic           add_dc;
    logic           lcd_wr_en;
    logic           lcd_wr_done;
    logic           err_timeout;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .NUM_REQ        (N),
        .ARB_MODE       (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_dc      (req_dc),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .busy        (busy),
        .lcd_data    (lcd_data),
        .add_dc      (add_dc),
        .lcd_wr_en   (lcd_wr_en),
        .lcd_wr_done (lcd_wr_done),
        .err_timeout (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [11:0] q_bytes[$];
    int   hold_err    = 0;
    int   foreign_rdy = 0;
    int   err_pulses  = 0;
    int   en_hi       = 0;
    int   err_enhi    = 0;
    logic [2:0] err_grant = '0;
    logic err_wren = 1'b0;
    bit   wr_auto = 1'b1;

    // Writer model plus byte monitor, sampled 1 ns after each edge.
    initial begin
        int cnt;
        logic pen;
        logic [8:0] pv;
        cnt = 0;
        pen = 1'b0;
        pv = '0;
        lcd_wr_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            lcd_wr_done = 1'b0;
            if (wr_auto && lcd_wr_en) begin
                cnt++;
                if (cnt == 4) begin
                    lcd_wr_done = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            if (lcd_wr_en && !pen) q_bytes.push_back({grant, add_dc, lcd_data});
            if (lcd_wr_en && pen && {add_dc, lcd_data} !== pv) hold_err++;
            if (lcd_wr_en) en_hi++;
            if ((req_ready & ~grant) != '0) foreign_rdy++;
            if (err_timeout) begin
                err_pulses++;
                err_grant = grant;
                err_wren = lcd_wr_en;
                err_enhi = en_hi;
            end
            pen = lcd_wr_en;
            pv = {add_dc, lcd_data};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "time limit");
    end

    task automatic send(int idx, logic [7:0] d, logic dc, logic last);
        int t;
        t = 0;
        req_valid[idx] = 1'b1;
        req_data[8*idx +: 8] = d;
        req_dc[idx] = dc;
        req_last[idx] = last;
        #1;
        while (!req_ready[idx] && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 200) chk($sformatf("hs_timeout_r%0d", idx), 32'(req_ready[idx]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        req_last[idx] = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int t;
        t = 0;
        while (busy && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_bytes.delete();
    endtask

    task automatic chk_byte(string tag, int k, logic [11:0] exp);
        if (k < q_bytes.size()) chk(tag, 32'(q_bytes[k]), 32'(exp));
        else chk(tag, 32'hDEAD, 32'(exp));
    endtask

    logic [11:0] exp3[8];

    initial begin
        rst = 1'b1;
        req_valid = 3'b111;
        req_data = '0;
        req_dc = '0;
        req_last = '0;

        // Reset holds everything at zero even with all requests up.
        @(posedge clk);
        #1;
        chk("t1_rst_grant", 32'(grant), 32'd0);
        chk("t1_rst_wren", 32'(lcd_wr_en), 32'd0);
        chk("t1_rst_data", 32'(lcd_data), 32'd0);
        chk("t1_rst_dc", 32'(add_dc), 32'd0);
        chk("t1_rst_err", 32'(err_timeout), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_grant", 32'(grant), 32'b001);
        chk("t1_ready", 32'(req_ready), 32'b001);
        chk("t1_wren_lat", 32'(lcd_wr_en), 32'd0);
        do_reset();

        // Single requester, three bytes.
        send(0, LCD_CASET, DC_CMD, 1'b0);
        send(0, 8'h00, DC_DAT, 1'b0);
        send(0, 8'h3F, DC_DAT, 1'b1);
        wait_idle("t2_idle");
        chk("t2_nbytes", 32'(q_bytes.size()), 32'd3);
        chk_byte("t2_b0", 0, {3'b001, 1'b0, 8'h2A});
        chk_byte("t2_b1", 1, {3'b001, 1'b1, 8'h00});
        chk_byte("t2_b2", 2, {3'b001, 1'b1, 8'h3F});
        chk("t2_grant_end", 32'(grant), 32'd0);
        chk("t2_wren_end", 32'(lcd_wr_en), 32'd0);

        // Round-robin contention between requesters 0 and 2.
        do_reset();
        fork
            begin
                send(0, 8'hA0, 1'b1, 1'b0);
                send(0, 8'hA1, 1'b1, 1'b1);
                send(0, 8'hA2, 1'b1, 1'b0);
                send(0, 8'hA3, 1'b1, 1'b1);
            end
            begin
                send(2, 8'hC0, 1'b1, 1'b0);
                send(2, 8'hC1, 1'b1, 1'b1);
                send(2, 8'hC2, 1'b1, 1'b0);
                send(2, 8'hC3, 1'b1, 1'b1);
            end
        join
        wait_idle("t3_idle");
        exp3[0] = {3'b001, 1'b1, 8'hA0};
        exp3[1] = {3'b001, 1'b1, 8'hA1};
        exp3[2] = {3'b100, 1'b1, 8'hC0};
        exp3[3] = {3'b100, 1'b1, 8'hC1};
        exp3[4] = {3'b001, 1'b1, 8'hA2};
        exp3[5] = {3'b001, 1'b1, 8'hA3};
        exp3[6] = {3'b100, 1'b1, 8'hC2};
        exp3[7] = {3'b100, 1'b1, 8'hC3};
        chk("t3_nbytes", 32'(q_bytes.size()), 32'd8);
        for (int k = 0; k < 8; k++) chk_byte($sformatf("t3_b%0d", k), k, exp3[k]);

        // Lock: requester 0 arrives while 1 owns the writer.
        do_reset();
        fork
            begin
                send(1, 8'hB0, 1'b0, 1'b0);
                send(1, 8'hB1, 1'b1, 1'b1);
            end
            begin
                int t;
                t = 0;
                while (grant !== 3'b010 && t < 50) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("t4_owner1", 32'(grant), 32'b010);
                send(0, 8'h55, 1'b1, 1'b1);
            end
        join
        wait_idle("t4_idle");
        chk("t4_nbytes", 32'(q_bytes.size()), 32'd3);
        chk_byte("t4_b0", 0, {3'b010, 1'b0, 8'hB0});
        chk_byte("t4_b1", 1, {3'b010, 1'b1, 8'hB1});
        chk_byte("t4_b2", 2, {3'b001, 1'b1, 8'h55});

        // Owner stalls mid-transaction for 5 cycles.
        do_reset();
        send(2, LCD_RAMWR, DC_CMD, 1'b0);
        begin
            int t;
            t = 0;
            while (lcd_wr_en && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5_wren_%0d", k), 32'(lcd_wr_en), 32'd0);
            chk($sformatf("t5_grant_%0d", k), 32'(grant), 32'b100);
            chk($sformatf("t5_busy_%0d", k), 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        send(2, 8'h11, DC_DAT, 1'b1);
        wait_idle("t5_idle");
        chk("t5_nbytes", 32'(q_bytes.size()), 32'd2);
        chk_byte("t5_b1", 1, {3'b100, 1'b1, 8'h11});

`ifdef LCD_ARB_TIMEOUT_EN
        // Watchdog abort, then async reset in the middle of WAIT_DONE.
        do_reset();
        wr_auto = 1'b0;
        err_pulses = 0;
        en_hi = 0;
        fork
            send(0, 8'hE0, 1'b1, 1'b1);
            send(1, 8'hE1, 1'b1, 1'b1);
        join
        chk("t6_err_pulses", 32'(err_pulses), 32'd1);
        chk("t6_err_grant", 32'(err_grant), 32'd0);
        chk("t6_err_wren", 32'(err_wren), 32'd0);
        chk("t6_wren_cycles", 32'(err_enhi), 32'd16);
        chk_byte("t6_next_owner", 1, {3'b010, 1'b1, 8'hE1});
        chk("t6_wren_b4rst", 32'(lcd_wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_wren", 32'(lcd_wr_en), 32'd0);
        chk("t6_async_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_auto = 1'b1;
`else
        chk("err_never", 32'(err_pulses), 32'd0);
`endif

        chk("hold_stable", 32'(hold_err), 32'd0);
        chk("no_foreign_ready", 32'(foreign_rdy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
